// File: rtl/axi_wr_pkg.sv
// ---------------------------------------------------------------------------
// axi_wr_pkg
//    Shared definitions for the AXI write-side sink and its helpers:
//       - burst type encodings (FIXED / INCR / WRAP / reserved)
//       - write response encodings (OKAY / SLVERR)
//       - FSM state constants for the write slave
//       - next_beat_addr(): address of the following beat of a burst
//    No ports (package).
// ---------------------------------------------------------------------------
package axi_wr_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Computed at 64 bits so callers of any address width can truncate.
   // For WRAP the container is (len+1)<<size bytes; with a legal (power of
   // two) length, masking the incremented address keeps the upper bits of
   // the aligned base and wraps the low offset back to zero at the boundary.
   function automatic logic [63:0] next_beat_addr(input logic [63:0] addr,
                                                  input logic [7:0]  len,
                                                  input logic [2:0]  size,
                                                  input logic [1:0]  burst);
      logic [63:0] step;
      logic [63:0] wrap_mask;
      logic [63:0] incr;
      logic [63:0] next;
      step      = 64'd1 << size;
      wrap_mask = (({56'd0, len} + 64'd1) << size) - 64'd1;
      incr      = addr + step;
      case (burst)
         BURST_INCR: next = incr;
         BURST_WRAP: next = (addr & ~wrap_mask) | (incr & wrap_mask);
         default:    next = addr;
      endcase
      return next;
   endfunction

endpackage

// File: rtl/axi_wr_addr_gen.sv
// ---------------------------------------------------------------------------
// axi_wr_addr_gen
//    Purely combinational next-beat address generator for AXI bursts.
//    Ports:
//       addr      in  [AW-1:0]  address of the current beat
//       len       in  [7:0]     beats minus one
//       size      in  [2:0]     log2 bytes per beat
//       burst     in  [1:0]     burst type
//       next_addr out [AW-1:0]  address of the following beat (mod 2^AW)
// ---------------------------------------------------------------------------
module axi_wr_addr_gen
   import axi_wr_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic [AW-1:0] addr,
   input  logic [7:0]    len,
   input  logic [2:0]    size,
   input  logic [1:0]    burst,
   output logic [AW-1:0] next_addr
);

   logic [63:0] wide_next;

   assign wide_next = next_beat_addr(64'(addr), len, size, burst);
   assign next_addr = wide_next[AW-1:0];

   // The bits above the address width are simply dropped (INCR wraps
   // modulo 2^AW).
   generate
      if (AW < 64) begin : g_trunc
         logic unused_hi;
         assign unused_hi = ^wide_next[63:AW];
      end
   endgenerate

endmodule

// File: rtl/axi_wr_slave.sv
// ---------------------------------------------------------------------------
// axi_wr_slave
//    AXI write-channel sink. Accepts one burst at a time (AW, then exactly
//    len+1 W beats, then B), checks the burst for protocol errors and answers
//    OKAY or SLVERR.
//    Optional backing store: define AXI_WR_SLV_MEM_EN to store accepted
//    beats in a MEM_DEPTH-word memory readable through dbg_addr/dbg_data.
//    Without it, write data is discarded and dbg_data reads as zero.
//    Ports:
//       clk, resetn                 clock, asynchronous active-low reset
//       axi_aw{addr,len,size,burst,valid} / axi_awready   address channel
//       axi_w{data,strb,last,valid} / axi_wready          data channel
//       axi_bresp, axi_bvalid / axi_bready                 response channel
//       burst_done                  one-cycle pulse on the B handshake
//       dbg_addr / dbg_data         backing-store read port (combinational)
// ---------------------------------------------------------------------------
module axi_wr_slave
   import axi_wr_pkg::*;
#(
   parameter int AW        = 32,
   parameter int DW        = 64,
   parameter int MEM_DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic [AW-1:0]                axi_awaddr,
   input  logic [7:0]                   axi_awlen,
   input  logic [2:0]                   axi_awsize,
   input  logic [1:0]                   axi_awburst,
   input  logic                         axi_awvalid,
   output logic                         axi_awready,
   input  logic [DW-1:0]                axi_wdata,
   input  logic [DW/8-1:0]              axi_wstrb,
   input  logic                         axi_wlast,
   input  logic                         axi_wvalid,
   output logic                         axi_wready,
   output logic [1:0]                   axi_bresp,
   output logic                         axi_bvalid,
   input  logic                         axi_bready,
   output logic                         burst_done,
   input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
   output logic [DW-1:0]                dbg_data
);

   localparam int         BYTE_LANES = DW / 8;
   localparam int         LANE_BITS  = $clog2(BYTE_LANES);
   localparam logic [2:0] MAX_SIZE   = 3'(LANE_BITS);

   logic [1:0]    state;
   logic [AW-1:0] addr_q;
   logic [7:0]    len_q;
   logic [2:0]    size_q;
   logic [1:0]    burst_q;
   logic [7:0]    beat_cnt;
   logic          err;

   logic [AW-1:0] next_addr;
   logic [AW-1:0] size_mask;
   logic          aw_err;
   logic          w_hs;
   logic          last_beat;
   logic          beat_err;

   axi_wr_addr_gen #(.AW(AW)) u_addr_gen (
      .addr      (addr_q),
      .len       (len_q),
      .size      (size_q),
      .burst     (burst_q),
      .next_addr (next_addr)
   );

   // Errors detectable from the address phase alone: a beat wider than the
   // bus, the reserved burst type, and WRAP bursts whose length is not 2/4/8/16
   // beats or whose start address is not aligned to the beat size.
   assign size_mask = AW'((64'd1 << axi_awsize) - 64'd1);
   assign aw_err = (axi_awsize > MAX_SIZE) ||
                   (axi_awburst == BURST_RSVD) ||
                   ((axi_awburst == BURST_WRAP) &&
                    (!(axi_awlen inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                     ((axi_awaddr & size_mask) != '0)));

   // wlast must be high on the final beat and only there; a misplaced wlast
   // flags the burst but the beat count still decides where it ends.
   assign w_hs      = axi_wvalid && axi_wready;
   assign last_beat = (beat_cnt == len_q);
   assign beat_err  = last_beat ? !axi_wlast : axi_wlast;

   // Main burst FSM. awready and wready are never high together, which keeps
   // at most one burst in flight and stops W from being taken in the same
   // cycle as its AW.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_IDLE;
         axi_awready <= 1'b0;
         axi_wready  <= 1'b0;
         axi_bvalid  <= 1'b0;
         axi_bresp   <= RESP_OKAY;
         burst_done  <= 1'b0;
         addr_q      <= '0;
         len_q       <= '0;
         size_q      <= '0;
         burst_q     <= '0;
         beat_cnt    <= '0;
         err         <= 1'b0;
      end else begin
         burst_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (axi_awvalid && axi_awready) begin
                  addr_q      <= axi_awaddr;
                  len_q       <= axi_awlen;
                  size_q      <= axi_awsize;
                  burst_q     <= axi_awburst;
                  beat_cnt    <= '0;
                  err         <= aw_err;
                  axi_awready <= 1'b0;
                  axi_wready  <= 1'b1;
                  state       <= ST_DATA;
               end else begin
                  axi_awready <= 1'b1;
               end
            end
            ST_DATA: begin
               if (w_hs) begin
                  err    <= err || beat_err;
                  addr_q <= next_addr;
                  if (last_beat) begin
                     axi_wready <= 1'b0;
                     axi_bvalid <= 1'b1;
                     axi_bresp  <= (err || beat_err) ? RESP_SLVERR : RESP_OKAY;
                     state      <= ST_RESP;
                  end else begin
                     beat_cnt <= beat_cnt + 8'd1;
                  end
               end
            end
            ST_RESP: begin
               if (axi_bvalid && axi_bready) begin
                  axi_bvalid  <= 1'b0;
                  burst_done  <= 1'b1;
                  axi_awready <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               axi_awready <= 1'b0;
               axi_wready  <= 1'b0;
               axi_bvalid  <= 1'b0;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef AXI_WR_SLV_MEM_EN
   localparam int IDX_BITS = $clog2(MEM_DEPTH);

   logic [DW-1:0]       mem [MEM_DEPTH];
   logic [IDX_BITS-1:0] mem_idx;

   assign mem_idx = addr_q[LANE_BITS +: IDX_BITS];

   // Beats of a burst already known to be faulty (including a misplaced
   // wlast on this very beat) are not stored. The store is deliberately
   // not reset.
   always_ff @(posedge clk) begin
      if (w_hs && !(err || beat_err)) begin
         for (int b = 0; b < BYTE_LANES; b++) begin
            if (axi_wstrb[b]) begin
               mem[mem_idx][b*8 +: 8] <= axi_wdata[b*8 +: 8];
            end
         end
      end
   end

   assign dbg_data = mem[dbg_addr];
`else
   logic unused_data;

   assign unused_data = ^{axi_wdata, axi_wstrb, dbg_addr};
   assign dbg_data    = '0;
`endif

endmodule

// File: tb/tb_axi_wr_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_wr_slave
//    Self-checking bench for axi_wr_slave: directed bursts from the test plan
//    followed by randomized bursts, checked against a burst-level model.
// ---------------------------------------------------------------------------
module tb_axi_wr_slave;

   localparam int AW        = 32;
   localparam int DW        = 64;
   localparam int MEM_DEPTH = 16;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [AW-1:0] axi_awaddr = '0;
   logic [7:0]    axi_awlen = '0;
   logic [2:0]    axi_awsize = '0;
   logic [1:0]    axi_awburst = '0;
   logic          axi_awvalid = 1'b0;
   logic          axi_awready;
   logic [DW-1:0] axi_wdata = '0;
   logic [7:0]    axi_wstrb = '0;
   logic          axi_wlast = 1'b0;
   logic          axi_wvalid = 1'b0;
   logic          axi_wready;
   logic [1:0]    axi_bresp;
   logic          axi_bvalid;
   logic          axi_bready = 1'b0;
   logic          burst_done;
   logic [3:0]    dbg_addr = '0;
   logic [DW-1:0] dbg_data;

   int testCount = 0;
   int failCount = 0;

   logic [63:0] memModel [MEM_DEPTH];
   logic [7:0]  memKnown [MEM_DEPTH];

   always #5 clk = ~clk;

   axi_wr_slave #(.AW(AW), .DW(DW), .MEM_DEPTH(MEM_DEPTH)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .axi_awaddr  (axi_awaddr),
      .axi_awlen   (axi_awlen),
      .axi_awsize  (axi_awsize),
      .axi_awburst (axi_awburst),
      .axi_awvalid (axi_awvalid),
      .axi_awready (axi_awready),
      .axi_wdata   (axi_wdata),
      .axi_wstrb   (axi_wstrb),
      .axi_wlast   (axi_wlast),
      .axi_wvalid  (axi_wvalid),
      .axi_wready  (axi_wready),
      .axi_bresp   (axi_bresp),
      .axi_bvalid  (axi_bvalid),
      .axi_bready  (axi_bready),
      .burst_done  (burst_done),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   // One comparison: counted, asserted, reported on mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Errors visible from the address phase, straight from the burst rules.
   function automatic bit modelLatchErr(input logic [31:0] addr, input logic [7:0] len,
                                        input logic [2:0] size, input logic [1:0] burst);
      bit e;
      e = 1'b0;
      if (size > 3) e = 1'b1;
      if (burst == 2'b11) e = 1'b1;
      if (burst == 2'b10) begin
         if (!(len == 1 || len == 3 || len == 7 || len == 15)) e = 1'b1;
         if ((addr % (32'd1 << size)) != 0) e = 1'b1;
      end
      return e;
   endfunction

   // Address of beat number 'beat' computed directly, not iteratively.
   function automatic logic [31:0] modelBeatAddr(input logic [31:0] addr, input logic [7:0] len,
                                                 input logic [2:0] size, input logic [1:0] burst,
                                                 input int beat);
      longint unsigned a, step, bnd, base, res;
      a    = addr;
      step = 64'd1 << size;
      bnd  = (longint'(len) + 1) * step;
      case (burst)
         2'b01:   res = a + longint'(beat) * step;
         2'b10: begin
            base = a - (a % bnd);
            res  = base + ((a - base + longint'(beat) * step) % bnd);
         end
         default: res = a;
      endcase
      return res[31:0];
   endfunction

   // Drive one complete burst and check handshakes and response.
   // lastBeat: the only beat carrying wlast (> len means none does).
   // bHold: cycles bready is held low. wLead: cycles W is offered before AW.
   task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst,
                                input int lastBeat, input int bHold, input int wLead);
      logic [63:0] data [$];
      logic [7:0]  strb [$];
      logic [1:0]  expResp;
      bit          errSoFar;
      int          beats;
      int          cycles;
      int          idx;
      errSoFar = modelLatchErr(addr, len, size, burst);
      for (int i = 0; i <= int'(len); i++) begin
         data.push_back({$urandom, $urandom});
         strb.push_back(8'($urandom));
      end
      for (int i = 0; i <= int'(len); i++) begin
         if ((i == int'(len)) != (i == lastBeat)) errSoFar = 1'b1;
         if (!errSoFar) begin
            idx = int'((modelBeatAddr(addr, len, size, burst, i) >> 3) % MEM_DEPTH);
            for (int b = 0; b < 8; b++) begin
               if (strb[i][b]) begin
                  memModel[idx][b*8 +: 8] = data[i][b*8 +: 8];
                  memKnown[idx][b] = 1'b1;
               end
            end
         end
      end
      expResp = errSoFar ? 2'b10 : 2'b00;

      axi_wdata = data[0];
      axi_wstrb = strb[0];
      axi_wlast = (lastBeat == 0);
      for (int c = 0; c < wLead; c++) begin
         axi_wvalid = 1'b1;
         @(negedge clk);
         checkOutput({tag, " wready early W"}, 64'(axi_wready), 64'd0);
      end

      axi_awaddr  = addr;
      axi_awlen   = len;
      axi_awsize  = size;
      axi_awburst = burst;
      axi_awvalid = 1'b1;
      axi_wvalid  = (wLead > 0);
      cycles = 0;
      while (!axi_awready && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput({tag, " awready"}, 64'(axi_awready), 64'd1);
      checkOutput({tag, " wready during AW"}, 64'(axi_wready), 64'd0);
      @(negedge clk);
      axi_awvalid = 1'b0;
      checkOutput({tag, " awready after AW"}, 64'(axi_awready), 64'd0);
      checkOutput({tag, " wready after AW"}, 64'(axi_wready), 64'd1);

      beats  = 0;
      cycles = 0;
      while (beats <= int'(len) && cycles < 400) begin
         axi_wdata  = data[beats];
         axi_wstrb  = strb[beats];
         axi_wlast  = (beats == lastBeat);
         axi_wvalid = ($urandom_range(0, 3) != 0);
         if (axi_wvalid && axi_wready) beats++;
         @(negedge clk);
         cycles++;
      end
      axi_wvalid = 1'b0;
      axi_wlast  = 1'b0;
      checkOutput({tag, " beats consumed"}, 64'(beats), 64'(int'(len) + 1));
      checkOutput({tag, " wready after last"}, 64'(axi_wready), 64'd0);

      axi_bready = 1'b0;
      for (int c = 0; c < bHold; c++) begin
         checkOutput({tag, " bvalid held"}, 64'(axi_bvalid), 64'd1);
         checkOutput({tag, " bresp held"}, 64'(axi_bresp), 64'(expResp));
         checkOutput({tag, " awready in RESP"}, 64'(axi_awready), 64'd0);
         @(negedge clk);
      end
      checkOutput({tag, " bvalid"}, 64'(axi_bvalid), 64'd1);
      checkOutput({tag, " bresp"}, 64'(axi_bresp), 64'(expResp));
      axi_bready = 1'b1;
      @(negedge clk);
      axi_bready = 1'b0;
      checkOutput({tag, " bvalid dropped"}, 64'(axi_bvalid), 64'd0);
      checkOutput({tag, " burst_done pulse"}, 64'(burst_done), 64'd1);
      checkOutput({tag, " awready after B"}, 64'(axi_awready), 64'd1);
      @(negedge clk);
      checkOutput({tag, " burst_done single"}, 64'(burst_done), 64'd0);
   endtask

   // Read back the debug port: stored bytes with the store, zero without.
   task automatic checkMem(input string tag);
      logic [63:0] mask;
      for (int i = 0; i < MEM_DEPTH; i++) begin
         dbg_addr = 4'(i);
         #1;
`ifdef AXI_WR_SLV_MEM_EN
         for (int b = 0; b < 8; b++) mask[b*8 +: 8] = {8{memKnown[i][b]}};
         if (memKnown[i] != 8'd0)
            checkOutput($sformatf("%s mem[%0d]", tag, i), dbg_data & mask, memModel[i] & mask);
`else
         mask = '0;
         checkOutput($sformatf("%s dbg_data[%0d]", tag, i), dbg_data | mask, 64'd0);
`endif
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] rAddr;
      logic [7:0]  rLen;
      logic [2:0]  rSize;
      logic [1:0]  rBurst;
      int          rLast;
      logic [7:0]  wrapLens [4];
      wrapLens[0] = 8'd1;
      wrapLens[1] = 8'd3;
      wrapLens[2] = 8'd7;
      wrapLens[3] = 8'd15;
      for (int i = 0; i < MEM_DEPTH; i++) begin
         memKnown[i] = 8'd0;
         memModel[i] = 64'd0;
      end

      // Reset state.
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset awready", 64'(axi_awready), 64'd0);
      checkOutput("reset wready", 64'(axi_wready), 64'd0);
      checkOutput("reset bvalid", 64'(axi_bvalid), 64'd0);
      checkOutput("reset bresp", 64'(axi_bresp), 64'd0);
      checkOutput("reset burst_done", 64'(burst_done), 64'd0);
      resetn = 1'b1;
      checkOutput("awready before first edge", 64'(axi_awready), 64'd0);
      @(negedge clk);
      checkOutput("awready first edge", 64'(axi_awready), 64'd1);

      // Directed bursts from the test plan.
      applyStimulus("incr basic", 32'h100, 8'd3, 3'd3, 2'b01, 3, 0, 0);
      checkMem("incr basic");
      applyStimulus("early wlast", 32'h200, 8'd3, 3'd3, 2'b01, 1, 0, 0);
      applyStimulus("wrap len3", 32'h18, 8'd3, 3'd3, 2'b10, 3, 0, 0);
      checkMem("wrap len3");
      applyStimulus("wrap len2", 32'h18, 8'd2, 3'd3, 2'b10, 2, 0, 0);
      applyStimulus("bready hold", 32'h40, 8'd1, 3'd3, 2'b01, 1, 5, 0);
      applyStimulus("w before aw", 32'h60, 8'd2, 3'd2, 2'b01, 2, 0, 3);
      applyStimulus("fixed", 32'h28, 8'd2, 3'd3, 2'b00, 2, 1, 1);
      applyStimulus("reserved burst", 32'h0, 8'd0, 3'd3, 2'b11, 0, 0, 0);
      applyStimulus("oversize", 32'h0, 8'd1, 3'd4, 2'b01, 1, 0, 0);

      // Reset in the middle of a burst, with strobes off so nothing is stored.
      axi_awaddr  = 32'h80;
      axi_awlen   = 8'd3;
      axi_awsize  = 3'd3;
      axi_awburst = 2'b01;
      axi_awvalid = 1'b1;
      @(negedge clk);
      axi_awvalid = 1'b0;
      axi_wstrb   = 8'd0;
      axi_wlast   = 1'b0;
      axi_wvalid  = 1'b1;
      @(negedge clk);
      axi_wvalid = 1'b0;
      #2 resetn = 1'b0;
      #1;
      checkOutput("midreset awready", 64'(axi_awready), 64'd0);
      checkOutput("midreset wready", 64'(axi_wready), 64'd0);
      checkOutput("midreset bvalid", 64'(axi_bvalid), 64'd0);
      checkOutput("midreset bresp", 64'(axi_bresp), 64'd0);
      checkOutput("midreset burst_done", 64'(burst_done), 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      checkOutput("post reset awready", 64'(axi_awready), 64'd1);
      checkOutput("post reset bvalid", 64'(axi_bvalid), 64'd0);
      applyStimulus("after reset", 32'h100, 8'd3, 3'd3, 2'b01, 3, 0, 0);

      // Randomized bursts.
      for (int n = 0; n < 24; n++) begin
         rBurst = 2'($urandom_range(0, 3));
         rSize  = 3'($urandom_range(0, 4));
         if (rBurst == 2'b10 && $urandom_range(0, 3) != 0)
            rLen = wrapLens[$urandom_range(0, 3)];
         else
            rLen = 8'($urandom_range(0, 15));
         rAddr = 32'($urandom_range(0, 4095));
         if ($urandom_range(0, 3) != 0) rAddr = rAddr & ~((32'd1 << rSize) - 32'd1);
         rLast = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 16)) : int'(rLen);
         applyStimulus($sformatf("rand%0d", n), rAddr, rLen, rSize, rBurst, rLast,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end
      checkMem("final");

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
